// File: rtl/chacha20_stream_ctrl_pkg.sv
// chacha20_stream_ctrl shared types: FSM encodings, block constants.
// Prefetch build option: CHACHA20_PREFETCH_EN.
package chacha20_stream_ctrl_pkg;

  localparam int          WORDS_PER_BLK = 16;
  localparam logic [31:0] CTR_MAX       = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_GEN,
    ST_STREAM,
    ST_ERR
  } state_e;

  typedef enum logic [1:0] {
    PF_IDLE,
    PF_LOAD,
    PF_GEN
  } pf_e;

  // word0 is the most significant 32 bits of the block
  function automatic logic [31:0] blk_word(
    input logic [511:0] blk,
    input logic [3:0]   idx
  );
    logic [511:0] sh;
    sh = blk << {idx, 5'b0};
    return sh[511:480];
  endfunction

endpackage

// File: rtl/chacha20_ks_buf.sv
// Keystream block buffer with word index; second (prefetch) slot
// is present only when CHACHA20_PREFETCH_EN is defined.
module chacha20_ks_buf
  import chacha20_stream_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         load_i,
  input  logic [511:0] blk_i,
  input  logic         pop_i,
  output logic [31:0]  word_o,
  output logic         empty_o,
`ifdef CHACHA20_PREFETCH_EN
  output logic         full_o,
`endif
  output logic         last_o
);

  logic [511:0] cur_q;
  logic         cur_v_q;
  logic [3:0]   idx_q;
  logic         pop_last;

  assign last_o   = idx_q == 4'(WORDS_PER_BLK - 1);
  assign pop_last = pop_i & last_o;
  assign word_o   = blk_word(cur_q, idx_q);
  assign empty_o  = ~cur_v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (flush_i) begin
      idx_q <= '0;
    end else if (pop_i) begin
      idx_q <= idx_q + 4'd1;
    end
  end

`ifdef CHACHA20_PREFETCH_EN
  logic [511:0] nxt_q;
  logic         nxt_v_q;

  assign full_o = nxt_v_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= '0;
      cur_v_q <= 1'b0;
      nxt_q   <= '0;
      nxt_v_q <= 1'b0;
    end else if (flush_i) begin
      cur_v_q <= 1'b0;
      nxt_v_q <= 1'b0;
    end else if (pop_last) begin
      // swap, or take a block arriving in the same cycle
      cur_v_q <= nxt_v_q | load_i;
      cur_q   <= nxt_v_q ? nxt_q : blk_i;
      nxt_v_q <= nxt_v_q & load_i;
      if (nxt_v_q & load_i) nxt_q <= blk_i;
    end else if (load_i) begin
      if (!cur_v_q) begin
        cur_q   <= blk_i;
        cur_v_q <= 1'b1;
      end else begin
        nxt_q   <= blk_i;
        nxt_v_q <= 1'b1;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q   <= '0;
      cur_v_q <= 1'b0;
    end else if (flush_i || pop_last) begin
      cur_v_q <= 1'b0;
    end else if (load_i) begin
      cur_q   <= blk_i;
      cur_v_q <= 1'b1;
    end
  end
`endif

endmodule

// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 stream controller: sequences the external block core, XORs keystream.
// CHACHA20_PREFETCH_EN overlaps next-block generation with streaming.
module chacha20_stream_ctrl
  import chacha20_stream_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  input  logic         s_last,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         busy,
  output logic         err,
  output logic         core_rst,
  output logic         core_en,
  output logic [31:0]  core_blk_cnt,
  output logic [255:0] core_key,
  output logic [95:0]  core_nonce,
  input  logic [511:0] core_out,
  input  logic         core_done
);

  state_e       state_q, state_d;
  logic [31:0]  ctr_q, ctr_d;
  logic         err_q, err_d;
  logic [255:0] key_q;
  logic [95:0]  nonce_q;
  logic         m_valid_q;
  logic [31:0]  m_data_q;

  logic         go, fire, blk_end;
  logic         ks_load, ks_empty, ks_last;
  logic [31:0]  ks_word;

  assign go      = start & ((state_q == ST_IDLE) | (state_q == ST_ERR));
  assign s_ready = (state_q == ST_STREAM) & ~ks_empty
                 & (~m_valid_q | m_ready);
  assign fire    = s_valid & s_ready;
  assign blk_end = fire & (s_last | ks_last);

  assign m_valid    = m_valid_q;
  assign m_data     = m_data_q;
  assign err        = err_q;
  assign busy       = (state_q == ST_LOAD) | (state_q == ST_GEN)
                    | (state_q == ST_STREAM);
  assign core_key   = key_q;
  assign core_nonce = nonce_q;

`ifdef CHACHA20_PREFETCH_EN
  pf_e  pf_q, pf_d;
  logic ks_full, pf_cap;

  assign pf_cap       = (pf_q == PF_GEN) & core_done;
  assign core_blk_cnt = (pf_q != PF_IDLE) ? ctr_q + 32'd1 : ctr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pf_q <= PF_IDLE;
    else        pf_q <= pf_d;
  end
`else
  assign core_blk_cnt = ctr_q;
`endif

  chacha20_ks_buf u_ks_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (go | (fire & s_last)),
    .load_i  (ks_load),
    .blk_i   (core_out),
    .pop_i   (fire),
    .word_o  (ks_word),
    .empty_o (ks_empty),
`ifdef CHACHA20_PREFETCH_EN
    .full_o  (ks_full),
`endif
    .last_o  (ks_last)
  );

  always_comb begin
    state_d  = state_q;
    ctr_d    = ctr_q;
    err_d    = err_q;
    core_rst = 1'b0;
    core_en  = 1'b0;
    ks_load  = 1'b0;
`ifdef CHACHA20_PREFETCH_EN
    pf_d     = pf_q;
`endif
    unique case (state_q)
      ST_IDLE, ST_ERR: begin
        if (start) begin
          state_d = ST_LOAD;
          ctr_d   = ctr_init;
          err_d   = 1'b0;
        end
      end
      ST_LOAD: begin
        core_rst = 1'b1;
        state_d  = ST_GEN;
      end
      ST_GEN: begin
        core_en = 1'b1;
        if (core_done) begin
          ks_load = 1'b1;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
`ifdef CHACHA20_PREFETCH_EN
        unique case (pf_q)
          PF_LOAD: begin
            core_rst = 1'b1;
            pf_d     = PF_GEN;
          end
          PF_GEN: begin
            core_en = 1'b1;
            if (core_done) begin
              ks_load = 1'b1;
              pf_d    = PF_IDLE;
            end
          end
          default: begin
            if (!ks_full && ctr_q != CTR_MAX && !blk_end)
              pf_d = PF_LOAD;
          end
        endcase
`endif
        if (blk_end) begin
`ifdef CHACHA20_PREFETCH_EN
          pf_d = PF_IDLE;
`endif
          if (s_last) begin
            state_d = ST_IDLE;
          end else if (ctr_q == CTR_MAX) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end else begin
            ctr_d = ctr_q + 32'd1;
`ifdef CHACHA20_PREFETCH_EN
            // an in-flight prefetch is handed to the main sequence
            if (ks_full || pf_cap)  state_d = ST_STREAM;
            else if (pf_q == PF_GEN) state_d = ST_GEN;
            else                     state_d = ST_LOAD;
`else
            state_d = ST_LOAD;
`endif
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ctr_q   <= ctr_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q   <= '0;
      nonce_q <= '0;
    end else if (go) begin
      key_q   <= key;
      nonce_q <= nonce;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (fire) begin
      m_valid_q <= 1'b1;
      m_data_q  <= s_data ^ ks_word;
    end else if (m_ready) begin
      m_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Bench for chacha20_stream_ctrl: behavioural ChaCha20 core,
// keystream scoreboard, RFC 8439 vectors, backpressure, counter exhaustion.
module tb_chacha20_stream_ctrl;

  localparam int ITERATIONS = 10;
  localparam logic [255:0] K0 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0] N1 = 96'h000000000000004a00000000;
  localparam logic [95:0] N2 = 96'h000000090000004a00000000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic         s_valid, s_ready, s_last;
  logic [31:0]  s_data;
  logic         m_valid, m_ready;
  logic [31:0]  m_data;
  logic         busy, err;
  logic         core_rst, core_en;
  logic [31:0]  core_blk_cnt;
  logic [255:0] core_key;
  logic [95:0]  core_nonce;
  logic [511:0] core_out;
  logic         core_done;

  chacha20_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .key(key), .nonce(nonce),
    .ctr_init(ctr_init), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .busy(busy), .err(err),
    .core_rst(core_rst), .core_en(core_en), .core_blk_cnt(core_blk_cnt),
    .core_key(core_key), .core_nonce(core_nonce),
    .core_out(core_out), .core_done(core_done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [31:0] a_i, b_i, c_i, d_i);
    logic [31:0] a, b, c, d;
    a = a_i; b = b_i; c = c_i; d = d_i;
    a += b; d ^= a; d = rotl(d, 16);
    c += d; b ^= c; b = rotl(b, 12);
    a += b; d ^= a; d = rotl(d, 8);
    c += d; b ^= c; b = rotl(b, 7);
    return {a, b, c, d};
  endfunction

  // keystream block serialised byte0-first into bits [511:504]
  function automatic logic [511:0] chacha_blk(input logic [255:0] k,
      input logic [95:0] n, input logic [31:0] c);
    logic [31:0]  s [16];
    logic [31:0]  x [16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = bswap(k[255-32*i -: 32]);
    s[12] = c;
    for (int i = 0; i < 3; i++) s[13+i] = bswap(n[95-32*i -: 32]);
    x = s;
    for (int rd = 0; rd < 10; rd++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    r = '0;
    for (int i = 0; i < 16; i++) r[511-32*i -: 32] = bswap(x[i] + s[i]);
    return r;
  endfunction

  // behavioural core: level done a few cycles after enable
  logic [2:0] lat;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_done <= 1'b0;
      core_out  <= '0;
      lat       <= '0;
    end else if (core_rst) begin
      core_done <= 1'b0;
      lat       <= '0;
    end else if (core_en && !core_done) begin
      if (lat == 3'd3) begin
        core_done <= 1'b1;
        core_out  <= chacha_blk(core_key, core_nonce, core_blk_cnt);
      end else begin
        lat <= lat + 3'd1;
      end
    end
  end

  logic [255:0] sess_key;
  logic [95:0]  sess_nonce;
  logic [31:0]  sess_ctr;
  int           in_idx;
  logic [31:0]  exp_q [$];
  logic [31:0]  out_log [$];
  logic [31:0]  ref_log [$];
  logic [31:0]  din [$];
  bit           hold_q;
  logic [31:0]  hold_d;

  function automatic logic [31:0] ks_word(input int i);
    logic [511:0] b;
    b = chacha_blk(sess_key, sess_nonce, sess_ctr + 32'(i / 16));
    return b[511-32*(i%16) -: 32];
  endfunction

  task automatic cycle(input bit sv, input logic [31:0] sd, input bit sl,
                       input bit mr, output bit fired);
    @(negedge clk);
    s_valid = sv; s_data = sd; s_last = sl; m_ready = mr;
    #1;
    if (hold_q) chk("hold", {m_valid, m_data}, {1'b1, hold_d});
    hold_q = m_valid && !m_ready;
    hold_d = m_data;
    if (m_valid && m_ready) begin
      if (exp_q.size() == 0) chk("extra", m_valid, 0);
      else chk("data", m_data, exp_q.pop_front());
      out_log.push_back(m_data);
    end
    fired = s_valid && s_ready;
    if (fired) begin
      exp_q.push_back(sd ^ ks_word(in_idx));
      in_idx++;
    end
  endtask

  task automatic drain();
    int cyc = 0;
    bit f;
    while ((exp_q.size() != 0 || m_valid) && cyc < 200) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b1, f);
      cyc++;
    end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic send(input int n, input bit rnd, input int budget,
                      output int acc);
    int cyc = 0;
    bit f, sv, mr;
    acc = 0;
    while (acc < n && cyc < budget) begin
      sv = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      mr = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      cycle(sv, din[acc], acc == n - 1, mr, f);
      if (f) acc++;
      cyc++;
    end
    drain();
  endtask

  task automatic start_sess(input logic [255:0] k, input logic [95:0] nn,
                            input logic [31:0] c);
    @(negedge clk);
    key = k; nonce = nn; ctr_init = c; start = 1'b1;
    sess_key = k; sess_nonce = nn; sess_ctr = c; in_idx = 0;
    out_log.delete();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_text();
    string txt;
    logic [31:0] w;
    int nw, bi;
    txt = {"Ladies and Gentlemen of the class of '99: If I could offer ",
           "you only one tip for the future, sunscreen would be it."};
    nw = (txt.len() + 3) / 4;
    din.delete();
    for (int i = 0; i < nw; i++) begin
      w = '0;
      for (int b = 0; b < 4; b++) begin
        bi = 4 * i + b;
        w = {w[23:0], (bi < txt.len()) ? txt[bi] : 8'h00};
      end
      din.push_back(w);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc;
    logic [255:0] rk;
    logic [95:0]  rn;
    rst_n = 1'b0; start = 1'b0; key = '0; nonce = '0; ctr_init = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
    hold_q = 1'b0; hold_d = '0; in_idx = 0;
    sess_key = '0; sess_nonce = '0; sess_ctr = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {busy, err, s_ready, m_valid, core_rst, core_en}, 0);
    chk("rst_dat", {m_data, core_blk_cnt}, 0);
    rst_n = 1'b1;

    // 1: single word, s_last mid-block
    start_sess(K0, N1, 32'd1);
    din = '{32'h4c616469};
    send(1, 1'b0, 200, acc);
    chk("t1_acc", acc, 1);
    chk("t1_word", out_log[0], 32'h6e2e359a);
    chk("t1_busy", busy, 0);

    // 2: RFC block function vector, zero plaintext
    start_sess(K0, N2, 32'd1);
    din.delete();
    for (int i = 0; i < 16; i++) din.push_back(32'h0);
    send(16, 1'b0, 200, acc);
    chk("t2_acc", acc, 16);
    chk("t2_w0", out_log[0], 32'h10f1e7e4);
    chk("t2_w1", out_log[1], 32'hd13b5915);
    chk("t2_w15", out_log[15], 32'ha2503c4e);

    // 3: sunscreen text spanning two blocks
    load_text();
    start_sess(K0, N1, 32'd1);
    send(din.size(), 1'b0, 400, acc);
    chk("t3_acc", acc, din.size());
    chk("t3_w0", out_log[0], 32'h6e2e359a);
    chk("t3_busy", busy, 0);
    ref_log = out_log;

    // 4: same text under random backpressure
    start_sess(K0, N1, 32'd1);
    send(din.size(), 1'b1, 2000, acc);
    chk("t4_len", out_log.size(), ref_log.size());
    for (int i = 0; i < out_log.size() && i < ref_log.size(); i++)
      chk("t4_seq", out_log[i], ref_log[i]);

    for (int it = 0; it < ITERATIONS; it++) begin
      for (int j = 0; j < 8; j++) rk[255-32*j -: 32] = $urandom();
      rn = {$urandom(), $urandom(), $urandom()};
      start_sess(rk, rn, 32'($urandom_range(0, 100)));
      din.delete();
      for (int j = $urandom_range(1, 40); j > 0; j--) din.push_back($urandom());
      send(din.size(), 1'b1, 2000, acc);
      chk("rnd_acc", acc, din.size());
      chk("rnd_busy", busy, 0);
    end

    // 5: counter exhaustion
    start_sess(K0, N2, 32'hFFFF_FFFF);
    din.delete();
    for (int i = 0; i < 20; i++) din.push_back(32'(i));
    send(20, 1'b0, 100, acc);
    chk("t5_acc", acc, 16);
    chk("t5_state", {err, s_ready, busy}, 3'b100);
    start_sess(K0, N1, 32'd1);
    chk("t5_clr", {err, busy}, 2'b01);
    din = '{32'h4c616469};
    send(1, 1'b0, 200, acc);
    chk("t5_word", out_log[0], 32'h6e2e359a);

    // 6: async reset while the core is generating
    start_sess(K0, N1, 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t6_gen", {busy, core_en, core_rst}, 3'b110);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_ctl", {busy, err, s_ready, m_valid, core_rst, core_en}, 0);
    chk("t6_dat", {m_data, core_blk_cnt}, 0);
    chk("t6_key", {|core_key, |core_nonce}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold_q = 1'b0;
    exp_q.delete();
    start_sess(K0, N1, 32'd1);
    din = '{32'h4c616469};
    send(1, 1'b0, 200, acc);
    chk("t6_word", out_log[0], 32'h6e2e359a);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
